// File: rtl/idu_pkg.sv
// idu_pkg: shared op classes, RV32I opcodes, immediate formats and the decoded-field bundle
package idu_pkg;
  typedef enum logic [3:0] {
    LUI     = 4'h0,
    AUIPC   = 4'h1,
    JAL     = 4'h2,
    JALR    = 4'h3,
    BRANCH  = 4'h4,
    LOAD    = 4'h5,
    STORE   = 4'h6,
    OPIMM   = 4'h7,
    OP      = 4'h8,
    FENCE   = 4'h9,
    SYSTEM  = 4'hA,
    ILLEGAL = 4'hF
  } op_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_e;

  typedef struct packed {
    op_e         op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        illegal;
  } dec_t;

  // Contents of the output register while in reset: no entry, op reads as ILLEGAL.
  localparam dec_t DEC_RESET = '{
    op: ILLEGAL, funct3: 3'd0, funct7b5: 1'b0, rd: 5'd0, rs1: 5'd0, rs2: 5'd0,
    imm: 32'd0, illegal: 1'b0
  };

  // Sign-extended immediate assembled from the scattered RV32I bit fields.
  function automatic logic [31:0] gen_imm(input logic [31:0] inst, input imm_fmt_e fmt);
    return fmt == IMM_I ? {{20{inst[31]}}, inst[31:20]} :
           fmt == IMM_S ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
           fmt == IMM_B ? {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
           fmt == IMM_U ? {inst[31:12], 12'b0} :
           fmt == IMM_J ? {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} :
           32'd0;
  endfunction
endpackage

// File: rtl/idu_inst_decoder.sv
// idu_inst_decoder: combinational RV32I field and immediate decode of one instruction word
module idu_inst_decoder
  import idu_pkg::*;
(
  input  logic [31:0] i_inst,
  output dec_t        o_dec
);
  op_e        w_op;
  imm_fmt_e   w_fmt;
  logic [7:0] w_f3_ok;
  logic       w_use_rd;
  logic       w_use_rs1;
  logic       w_use_rs2;
  logic       w_legal;

  // classify the opcode: op class, immediate format, register usage and the set of valid funct3 values
  always_comb begin
    w_op      = ILLEGAL;
    w_fmt     = IMM_NONE;
    w_f3_ok   = 8'h00;
    w_use_rd  = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    case (i_inst[6:0])
      OPC_LUI:    begin w_op = LUI;    w_fmt = IMM_U;    w_f3_ok = 8'hFF; w_use_rd = 1'b1; end
      OPC_AUIPC:  begin w_op = AUIPC;  w_fmt = IMM_U;    w_f3_ok = 8'hFF; w_use_rd = 1'b1; end
      OPC_JAL:    begin w_op = JAL;    w_fmt = IMM_J;    w_f3_ok = 8'hFF; w_use_rd = 1'b1; end
      OPC_JALR:   begin w_op = JALR;   w_fmt = IMM_I;    w_f3_ok = 8'h01; w_use_rd = 1'b1; w_use_rs1 = 1'b1; end
      OPC_BRANCH: begin w_op = BRANCH; w_fmt = IMM_B;    w_f3_ok = 8'hF3; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
      OPC_LOAD:   begin w_op = LOAD;   w_fmt = IMM_I;    w_f3_ok = 8'h37; w_use_rd = 1'b1; w_use_rs1 = 1'b1; end
      OPC_STORE:  begin w_op = STORE;  w_fmt = IMM_S;    w_f3_ok = 8'h07; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
      OPC_OPIMM:  begin w_op = OPIMM;  w_fmt = IMM_I;    w_f3_ok = 8'hFF; w_use_rd = 1'b1; w_use_rs1 = 1'b1; end
      OPC_OP:     begin w_op = OP;     w_fmt = IMM_NONE; w_f3_ok = 8'hFF; w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
      OPC_FENCE:  begin w_op = FENCE;  w_fmt = IMM_I;    w_f3_ok = 8'h01; w_use_rd = 1'b1; w_use_rs1 = 1'b1; end
      OPC_SYSTEM: begin w_op = SYSTEM; w_fmt = IMM_I;    w_f3_ok = 8'hEF; w_use_rd = 1'b1; w_use_rs1 = 1'b1; end
      default:    ;
    endcase
  end

  assign w_legal = (i_inst[1:0] == 2'b11) && (w_op != ILLEGAL) && w_f3_ok[i_inst[14:12]];

  // Illegal words keep the raw funct fields for trap reporting but carry no registers or immediate.
  assign o_dec = '{
    op:       w_legal ? w_op : ILLEGAL,
    funct3:   i_inst[14:12],
    funct7b5: i_inst[30],
    rd:       (w_legal && w_use_rd)  ? i_inst[11:7]  : 5'd0,
    rs1:      (w_legal && w_use_rs1) ? i_inst[19:15] : 5'd0,
    rs2:      (w_legal && w_use_rs2) ? i_inst[24:20] : 5'd0,
    imm:      w_legal ? gen_imm(i_inst, w_fmt) : 32'd0,
    illegal:  ~w_legal
  };
endmodule

// File: rtl/idu_decode_stage.sv
// idu_decode_stage: single-entry decode register between fetch FIFO and EXU with early JAL redirect
module idu_decode_stage
  import idu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h30000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_pred_pc,
  input  logic        in_pred_res,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_pred_pc,
  output logic        out_pred_res,
  output op_e         out_op,
  output logic [2:0]  out_funct3,
  output logic        out_funct7b5,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [31:0] out_imm,
  output logic        out_illegal,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);
  dec_t        w_dec;
  logic        w_accept;
  logic        w_jal_mis;
  logic [31:0] w_jal_tgt;

  logic        r_valid;
  logic        r_redirect;
  logic [31:0] r_redirect_pc;
  logic [31:0] r_pc;
  logic [31:0] r_pred_pc;
  logic        r_pred_res;
  dec_t        r_dec;

  idu_inst_decoder u_dec (
    .i_inst (in_inst),
    .o_dec  (w_dec)
  );

  // A pending redirect blocks intake so the wrong-path bundle behind the JAL is never taken.
  assign in_ready  = (~r_valid | out_ready) & ~r_redirect & ~flush & ~reset;
  assign w_accept  = in_valid & in_ready;
  assign w_jal_tgt = in_pc + w_dec.imm;
  assign w_jal_mis = (w_dec.op == JAL) && ((in_pred_pc != w_jal_tgt) || !in_pred_res);

  // output register, handshake state and the one-cycle redirect pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid       <= 1'b0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= 32'd0;
      r_pc          <= RESET_PC;
      r_pred_pc     <= RESET_PC;
      r_pred_res    <= 1'b0;
      r_dec         <= DEC_RESET;
    end else begin
      r_valid    <= flush ? 1'b0 : w_accept ? 1'b1 : out_ready ? 1'b0 : r_valid;
      r_redirect <= w_accept & w_jal_mis;
      if (w_accept && w_jal_mis) r_redirect_pc <= w_jal_tgt;
      if (w_accept) begin
        r_dec      <= w_dec;
        r_pc       <= in_pc;
        r_pred_pc  <= w_jal_mis ? w_jal_tgt : in_pred_pc;
        r_pred_res <= in_pred_res | w_jal_mis;
      end
    end
  end

  assign out_valid      = r_valid;
  assign out_pc         = r_pc;
  assign out_pred_pc    = r_pred_pc;
  assign out_pred_res   = r_pred_res;
  assign out_op         = r_dec.op;
  assign out_funct3     = r_dec.funct3;
  assign out_funct7b5   = r_dec.funct7b5;
  assign out_rd         = r_dec.rd;
  assign out_rs1        = r_dec.rs1;
  assign out_rs2        = r_dec.rs2;
  assign out_imm        = r_dec.imm;
  assign out_illegal    = r_dec.illegal;
  assign redirect_valid = r_redirect;
  assign redirect_pc    = r_redirect_pc;
endmodule

// File: tb/tb_idu_decode_stage.sv
// tb_idu_decode_stage: vector table, directed corner sequences and random traffic against a reference model
module tb_idu_decode_stage;
  localparam logic [31:0] RPC = 32'h30000000;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, in_ready, in_pred_res, out_valid, out_ready, out_pred_res;
  logic [31:0] in_inst, in_pc, in_pred_pc, out_pc, out_pred_pc, out_imm, redirect_pc;
  logic [3:0]  out_op;
  logic [2:0]  out_funct3;
  logic        out_funct7b5, out_illegal, redirect_valid;
  logic [4:0]  out_rd, out_rs1, out_rs2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  idu_decode_stage #(.RESET_PC(RPC)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .in_pred_pc(in_pred_pc), .in_pred_res(in_pred_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_pred_pc(out_pred_pc),
    .out_pred_res(out_pred_res), .out_op(out_op), .out_funct3(out_funct3),
    .out_funct7b5(out_funct7b5), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .out_illegal(out_illegal),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        ill;
    logic [31:0] pc, ppc;
    logic        pres;
    logic        red;
    logic [31:0] rpc;
  } exp_t;

  logic        m_valid, m_red;
  logic [31:0] m_rpc;
  exp_t        m_ent;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected decode straight from the ISA field layout, using arithmetic shifts for sign extension.
  function automatic exp_t ref_dec(input logic [31:0] inst, pc, ppc, input logic pres);
    exp_t        e;
    logic [7:0]  ok;
    logic        urd, urs1, urs2;
    logic [3:0]  op;
    logic [31:0] imm, iimm, simm, bimm, uimm, jimm;
    iimm = 32'($signed(inst) >>> 20);
    simm = (iimm & 32'hFFFF_FFE0) | 32'(inst[11:7]);
    bimm = (32'($signed(inst) >>> 19) & 32'hFFFF_F000) | (32'(inst[7]) << 11) |
           (32'(inst[30:25]) << 5) | (32'(inst[11:8]) << 1);
    uimm = inst & 32'hFFFF_F000;
    jimm = (32'($signed(inst) >>> 11) & 32'hFFF0_0000) | (32'(inst[19:12]) << 12) |
           (32'(inst[20]) << 11) | (32'(inst[30:21]) << 1);
    ok = 8'h00; op = 4'hF; imm = 32'd0; urd = 0; urs1 = 0; urs2 = 0;
    case (inst[6:0])
      7'h37: begin op = 4'd0;  ok = 8'hFF; urd = 1; imm = uimm; end
      7'h17: begin op = 4'd1;  ok = 8'hFF; urd = 1; imm = uimm; end
      7'h6F: begin op = 4'd2;  ok = 8'hFF; urd = 1; imm = jimm; end
      7'h67: begin op = 4'd3;  ok = 8'h01; urd = 1; urs1 = 1; imm = iimm; end
      7'h63: begin op = 4'd4;  ok = 8'hF3; urs1 = 1; urs2 = 1; imm = bimm; end
      7'h03: begin op = 4'd5;  ok = 8'h37; urd = 1; urs1 = 1; imm = iimm; end
      7'h23: begin op = 4'd6;  ok = 8'h07; urs1 = 1; urs2 = 1; imm = simm; end
      7'h13: begin op = 4'd7;  ok = 8'hFF; urd = 1; urs1 = 1; imm = iimm; end
      7'h33: begin op = 4'd8;  ok = 8'hFF; urd = 1; urs1 = 1; urs2 = 1; end
      7'h0F: begin op = 4'd9;  ok = 8'h01; urd = 1; urs1 = 1; imm = iimm; end
      7'h73: begin op = 4'd10; ok = 8'hEF; urd = 1; urs1 = 1; imm = iimm; end
      default: ;
    endcase
    e.ill = ~ok[inst[14:12]];
    if (e.ill) begin op = 4'hF; imm = 32'd0; urd = 0; urs1 = 0; urs2 = 0; end
    e.op = op; e.f3 = inst[14:12]; e.f7 = inst[30];
    e.rd = urd ? inst[11:7] : 5'd0;
    e.rs1 = urs1 ? inst[19:15] : 5'd0;
    e.rs2 = urs2 ? inst[24:20] : 5'd0;
    e.imm = imm; e.pc = pc;
    e.rpc = pc + jimm;
    e.red = (op == 4'd2) && (ppc != e.rpc || !pres);
    e.ppc = e.red ? e.rpc : ppc;
    e.pres = e.red ? 1'b1 : pres;
    return e;
  endfunction

  // One clock: drive inputs, check in_ready, advance the model, check registered outputs.
  task automatic step(input logic v, input logic [31:0] inst, pc, ppc, input logic pres,
                      input logic ordy, input logic fl, input logic rst);
    logic exp_ready, acc;
    exp_t e;
    in_valid = v; in_inst = inst; in_pc = pc; in_pred_pc = ppc; in_pred_res = pres;
    out_ready = ordy; flush = fl; reset = rst;
    #1;
    exp_ready = (!m_valid || ordy) && !m_red && !fl && !rst;
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    acc = v && exp_ready;
    e = ref_dec(inst, pc, ppc, pres);
    if (rst) begin
      m_valid = 0; m_red = 0; m_rpc = 32'd0;
      m_ent = '0; m_ent.op = 4'hF; m_ent.pc = RPC; m_ent.ppc = RPC;
    end else if (fl) begin
      m_valid = 0; m_red = 0;
    end else begin
      m_red = acc && e.red;
      if (acc && e.red) m_rpc = e.rpc;
      if (acc) begin m_valid = 1; m_ent = e; end
      else if (ordy) m_valid = 0;
    end
    @(posedge clock); #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("redirect_valid", 32'(redirect_valid), 32'(m_red));
    if (m_red) chk("redirect_pc", redirect_pc, m_rpc);
    if (m_valid) begin
      chk("out_op", 32'(out_op), 32'(m_ent.op));
      chk("out_funct3", 32'(out_funct3), 32'(m_ent.f3));
      chk("out_funct7b5", 32'(out_funct7b5), 32'(m_ent.f7));
      chk("out_rd", 32'(out_rd), 32'(m_ent.rd));
      chk("out_rs1", 32'(out_rs1), 32'(m_ent.rs1));
      chk("out_rs2", 32'(out_rs2), 32'(m_ent.rs2));
      chk("out_imm", out_imm, m_ent.imm);
      chk("out_illegal", 32'(out_illegal), 32'(m_ent.ill));
      chk("out_pc", out_pc, m_ent.pc);
      chk("out_pred_pc", out_pred_pc, m_ent.ppc);
      chk("out_pred_res", 32'(out_pred_res), 32'(m_ent.pres));
    end
  endtask

  typedef struct {
    logic [31:0] inst, pc, ppc;
    logic        pres;
    logic [3:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        ill, red;
    logic [31:0] xppc;
    logic        xpres;
  } vec_t;

  vec_t vt[10];

  function automatic logic [31:0] addi(input int rd, input int imm);
    return (32'(imm) << 20) | (32'(rd) << 7) | 32'h13;
  endfunction

  logic [6:0]  opcs[12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h00};
  logic [31:0] r_inst, r_pc, r_ppc;
  exp_t        r_e;

  initial begin
    m_valid = 0; m_red = 0; m_rpc = 0; m_ent = '0;
    vt[0] = '{32'h00500093, RPC, RPC + 4, 0, 4'd7,  5'd1, 5'd0, 5'd0, 32'd5,          0, 0, RPC + 4, 0};
    vt[1] = '{32'h008000EF, RPC, RPC + 4, 0, 4'd2,  5'd1, 5'd0, 5'd0, 32'd8,          0, 1, RPC + 8, 1};
    vt[2] = '{32'h008000EF, RPC, RPC + 8, 1, 4'd2,  5'd1, 5'd0, 5'd0, 32'd8,          0, 0, RPC + 8, 1};
    vt[3] = '{32'hFFFFFFFF, RPC, RPC + 4, 0, 4'hF,  5'd0, 5'd0, 5'd0, 32'd0,          1, 0, RPC + 4, 0};
    vt[4] = '{32'h123452B7, RPC, RPC + 4, 0, 4'd0,  5'd5, 5'd0, 5'd0, 32'h12345000,   0, 0, RPC + 4, 0};
    vt[5] = '{32'h0020A423, RPC, RPC + 4, 0, 4'd6,  5'd0, 5'd1, 5'd2, 32'd8,          0, 0, RPC + 4, 0};
    vt[6] = '{32'hFE208EE3, RPC, RPC + 4, 1, 4'd4,  5'd0, 5'd1, 5'd2, 32'hFFFFFFFC,   0, 0, RPC + 4, 1};
    vt[7] = '{32'h00013083, RPC, RPC + 4, 0, 4'hF,  5'd0, 5'd0, 5'd0, 32'd0,          1, 0, RPC + 4, 0};
    vt[8] = '{32'h002081B3, RPC, RPC + 4, 0, 4'd8,  5'd3, 5'd1, 5'd2, 32'd0,          0, 0, RPC + 4, 0};
    vt[9] = '{32'h00000001, RPC, RPC + 4, 0, 4'hF,  5'd0, 5'd0, 5'd0, 32'd0,          1, 0, RPC + 4, 0};

    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("reset out_pc", out_pc, RPC);
    chk("reset out_pred_pc", out_pred_pc, RPC);
    chk("reset out_op", 32'(out_op), 32'hF);
    chk("reset redirect_pc", redirect_pc, 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    step(0, 0, 0, 0, 0, 1, 0, 0);

    for (int i = 0; i < 10; i++) begin
      step(1, vt[i].inst, vt[i].pc, vt[i].ppc, vt[i].pres, 1, 0, 0);
      chk("vec out_valid", 32'(out_valid), 32'd1);
      chk("vec out_op", 32'(out_op), 32'(vt[i].op));
      chk("vec out_rd", 32'(out_rd), 32'(vt[i].rd));
      chk("vec out_rs1", 32'(out_rs1), 32'(vt[i].rs1));
      chk("vec out_rs2", 32'(out_rs2), 32'(vt[i].rs2));
      chk("vec out_imm", out_imm, vt[i].imm);
      chk("vec out_illegal", 32'(out_illegal), 32'(vt[i].ill));
      chk("vec redirect_valid", 32'(redirect_valid), 32'(vt[i].red));
      chk("vec out_pred_pc", out_pred_pc, vt[i].xppc);
      chk("vec out_pred_res", 32'(out_pred_res), 32'(vt[i].xpres));
      if (vt[i].red) begin
        chk("vec redirect_pc", redirect_pc, vt[i].xppc);
        chk("vec in_ready during redirect", 32'(in_ready), 32'd0);
      end
      step(0, 0, 0, 0, 0, 1, 0, 0);
      chk("vec redirect one cycle", 32'(redirect_valid), 32'd0);
    end

    step(1, addi(1, 100), 32'h100, 32'h104, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, addi(2, 200), 32'h104, 32'h108, 0, 0, 0, 0);
      chk("stall hold imm", out_imm, 32'd100);
    end
    step(1, addi(2, 200), 32'h104, 32'h108, 0, 1, 0, 0);
    chk("release next imm", out_imm, 32'd200);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    chk("release no dup", 32'(out_valid), 32'd0);

    for (int i = 0; i < 8; i++) begin
      step(1, addi(i + 1, i), 32'h200 + 32'(4 * i), 32'h204 + 32'(4 * i), 0, 1, 0, 0);
      chk("stream imm", out_imm, 32'(i));
      chk("stream rd", 32'(out_rd), 32'(i + 1));
    end
    step(0, 0, 0, 0, 0, 1, 0, 0);

    step(1, addi(3, 7), 32'h300, 32'h304, 0, 0, 0, 0);
    step(1, addi(4, 9), 32'h304, 32'h308, 0, 1, 1, 0);
    chk("flush out_valid", 32'(out_valid), 32'd0);
    chk("flush redirect_valid", 32'(redirect_valid), 32'd0);
    step(0, 0, 0, 0, 0, 1, 0, 0);

    step(1, addi(5, 11), 32'h400, 32'h404, 0, 0, 0, 0);
    step(1, addi(6, 12), 32'h404, 32'h408, 0, 0, 0, 1);
    chk("midreset out_valid", 32'(out_valid), 32'd0);
    chk("midreset out_pc", out_pc, RPC);
    step(0, 0, 0, 0, 0, 1, 0, 0);

    for (int i = 0; i < 600; i++) begin
      r_inst = (32'($urandom) & 32'hFFFF_FF80) | 32'(opcs[$urandom_range(0, 11)]);
      r_pc = 32'($urandom) & 32'hFFFF_FFFC;
      r_e = ref_dec(r_inst, r_pc, 32'd0, 1'b0);
      r_ppc = ($urandom_range(0, 1) == 1) ? r_e.rpc : 32'($urandom) & 32'hFFFF_FFFC;
      step($urandom_range(0, 3) != 0, r_inst, r_pc, r_ppc, 1'($urandom_range(0, 1)),
           $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0, $urandom_range(0, 99) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
